// File: rtl/cpu_register_dump.sv
// Register-file readback engine: walks an inclusive (possibly wrapping) address range,
// packs two 4-bit register values per byte and streams the bytes over valid/ready.
module cpu_register_dump #(
    parameter int unsigned NUMBER_OF_REGISTERS = 256,
    localparam int unsigned ADDRESS_WIDTH = $clog2(NUMBER_OF_REGISTERS)
) (
    input  logic                     clock_in,
    input  logic                     reset_in,
    input  logic                     start_in,
    input  logic                     abort_in,
    input  logic [ADDRESS_WIDTH-1:0] first_address_in,
    input  logic [ADDRESS_WIDTH-1:0] last_address_in,
    output logic [ADDRESS_WIDTH-1:0] read_register_address_out,
    input  logic signed [3:0]        read_data_in,
    output logic [7:0]               byte_data_out,
    output logic                     byte_valid_out,
    input  logic                     byte_ready_in,
    output logic                     byte_last_out,
    output logic                     busy_out,
    output logic                     done_out
);

    typedef enum logic [2:0] {
        StIdle,
        StReadLo,
        StReadHi,
        StSend,
        StDone
    } state_e;

    state_e                   state_q, state_d;
    logic [ADDRESS_WIDTH-1:0] address_q, address_d;
    logic [ADDRESS_WIDTH-1:0] last_q, last_d;
    logic [7:0]               byte_q, byte_d;
    logic                     final_q, final_d;
    logic [ADDRESS_WIDTH-1:0] address_next;
    logic                     at_last;

    // Explicit wrap so non-power-of-two register files also walk correctly.
    assign address_next = (address_q == ADDRESS_WIDTH'(NUMBER_OF_REGISTERS - 1)) ?
                          '0 : address_q + 1'b1;
    assign at_last      = (address_q == last_q);

    always_ff @(posedge clock_in or negedge reset_in) begin
        if (!reset_in) begin
            state_q   <= StIdle;
            address_q <= '0;
            last_q    <= '0;
            byte_q    <= '0;
            final_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            address_q <= address_d;
            last_q    <= last_d;
            byte_q    <= byte_d;
            final_q   <= final_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        address_d = address_q;
        last_d    = last_q;
        byte_d    = byte_q;
        final_d   = final_q;
        unique case (state_q)
            StIdle: begin
                if (start_in) begin
                    address_d = first_address_in;
                    last_d    = last_address_in;
                    final_d   = 1'b0;
                    state_d   = StReadLo;
                end
            end
            StReadLo: begin
                if (abort_in) begin
                    state_d = StIdle;
                end else begin
                    byte_d[3:0] = read_data_in;
                    if (at_last) begin
                        // Odd count: pad the high nibble and do not advance the address.
                        byte_d[7:4] = 4'b0000;
                        final_d     = 1'b1;
                        state_d     = StSend;
                    end else begin
                        address_d = address_next;
                        state_d   = StReadHi;
                    end
                end
            end
            StReadHi: begin
                if (abort_in) begin
                    state_d = StIdle;
                end else begin
                    byte_d[7:4] = read_data_in;
                    final_d     = at_last;
                    address_d   = address_next;
                    state_d     = StSend;
                end
            end
            StSend: begin
                if (abort_in) begin
                    state_d = StIdle;
                end else if (byte_ready_in) begin
                    state_d = final_q ? StDone : StReadLo;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign read_register_address_out = address_q;
    assign byte_data_out             = byte_q;
    assign byte_valid_out            = (state_q == StSend);
    assign byte_last_out             = (state_q == StSend) && final_q;
    assign busy_out                  = (state_q != StIdle);
    assign done_out                  = (state_q == StDone);

endmodule

// File: tb/tb_cpu_register_dump.sv
// Self-checking bench for cpu_register_dump: directed table, random dumps against a
// range/packing model, and hand-written abort and reset sequences.
module tb_cpu_register_dump;

    localparam int unsigned N = 256;

    logic              clock_in = 1'b0;
    logic              reset_in = 1'b1;
    logic              start_in = 1'b0;
    logic              abort_in = 1'b0;
    logic              byte_ready_in = 1'b0;
    logic [7:0]        first_address_in = '0;
    logic [7:0]        last_address_in = '0;
    logic [7:0]        read_register_address_out;
    logic signed [3:0] read_data_in;
    logic [7:0]        byte_data_out;
    logic              byte_valid_out;
    logic              byte_last_out;
    logic              busy_out;
    logic              done_out;

    logic [3:0] regfile [N];

    int applied = 0;
    int miscompares = 0;

    typedef struct {
        logic [7:0] data;
        logic       last;
    } exp_t;
    exp_t exp_q[$];

    typedef struct {
        logic [7:0] f;
        logic [7:0] l;
        logic [3:0] r[4];
        logic [7:0] b[2];
        int         nb;
        int         stall;
        bit         lat;
        bit         pulse;
    } vec_t;

    always #5 clock_in = ~clock_in;

    assign read_data_in = regfile[read_register_address_out];

    cpu_register_dump #(
        .NUMBER_OF_REGISTERS(N)
    ) dut (
        .clock_in                  (clock_in),
        .reset_in                  (reset_in),
        .start_in                  (start_in),
        .abort_in                  (abort_in),
        .first_address_in          (first_address_in),
        .last_address_in           (last_address_in),
        .read_register_address_out (read_register_address_out),
        .read_data_in              (read_data_in),
        .byte_data_out             (byte_data_out),
        .byte_valid_out            (byte_valid_out),
        .byte_ready_in             (byte_ready_in),
        .byte_last_out             (byte_last_out),
        .busy_out                  (busy_out),
        .done_out                  (done_out)
    );

    function automatic void check(input string name, input logic [31:0] act,
                                  input logic [31:0] req);
        applied++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, req);
        end
    endfunction

    // Expected byte stream from the range rule: count registers, pair them low-first.
    function automatic void build_model(input logic [7:0] f, input logic [7:0] l);
        int count;
        exp_t e;
        logic [3:0] hi;
        count = ((int'(l) - int'(f) + N) % N) + 1;
        exp_q.delete();
        for (int i = 0; i < count; i += 2) begin
            hi     = (i + 1 < count) ? regfile[(int'(f) + i + 1) % N] : 4'h0;
            e.data = {hi, regfile[(int'(f) + i) % N]};
            e.last = (i + 2 >= count);
            exp_q.push_back(e);
        end
    endfunction

    task automatic do_dump(input logic [7:0] f, input logic [7:0] l,
                           input int unsigned ready_pct, input int stall,
                           input bit chk_lat, input bit pulse_start, input string tag);
        int idx, cyc, first_valid, last_hs, stalls;
        bit fin, prev_stall, ready;
        logic [7:0] prev_data, prev_addr;
        idx = 0; first_valid = -1; last_hs = -10; stalls = 0;
        fin = 0; prev_stall = 0; prev_data = '0; prev_addr = '0;
        @(negedge clock_in);
        start_in = 1'b1; first_address_in = f; last_address_in = l; byte_ready_in = 1'b0;
        @(negedge clock_in);
        start_in = 1'b0;
        cyc = 1;
        while (!fin && cyc < 300) begin
            check({tag, " busy"}, busy_out, 1);
            if (prev_stall) begin
                check({tag, " stall valid"}, byte_valid_out, 1);
                check({tag, " stall data"}, byte_data_out, prev_data);
                check({tag, " stall addr"}, read_register_address_out, prev_addr);
            end
            prev_stall = 0;
            start_in = pulse_start && (cyc == 2);
            if (start_in) begin
                first_address_in = ~f;
                last_address_in  = ~f;
            end
            if (done_out) begin
                fin = 1;
                check({tag, " done after last handshake"}, last_hs, cyc - 1);
                check({tag, " byte count"}, idx, exp_q.size());
            end else if (byte_valid_out) begin
                if (first_valid < 0) first_valid = cyc;
                if (stalls < stall) begin
                    ready = 0;
                    stalls++;
                end else begin
                    ready = ($urandom_range(99) < ready_pct);
                end
                if (ready) begin
                    if (idx < exp_q.size()) begin
                        check({tag, " data"}, byte_data_out, exp_q[idx].data);
                        check({tag, " last"}, byte_last_out, exp_q[idx].last);
                    end else begin
                        check({tag, " extra byte"}, 1, 0);
                    end
                    idx++;
                    last_hs = cyc;
                end else begin
                    prev_stall = 1;
                    prev_data  = byte_data_out;
                    prev_addr  = read_register_address_out;
                end
                byte_ready_in = ready;
            end else begin
                byte_ready_in = 1'($urandom_range(1));
            end
            @(negedge clock_in);
            cyc++;
        end
        start_in = 1'b0;
        byte_ready_in = 1'b0;
        if (!fin) check({tag, " timeout"}, 0, 1);
        check({tag, " idle busy"}, busy_out, 0);
        check({tag, " idle done"}, done_out, 0);
        check({tag, " idle valid"}, byte_valid_out, 0);
        if (chk_lat) check({tag, " latency"}, first_valid, 3);
    endtask

    vec_t tbl[5];

    initial begin
        tbl[0] = '{8'd0,   8'd3,  '{4'h0, 4'h1, 4'hF, 4'h7}, '{8'h10, 8'h7F}, 2, 0, 1'b1, 1'b0};
        tbl[1] = '{8'd5,   8'd7,  '{4'h2, 4'h8, 4'h3, 4'h0}, '{8'h82, 8'h03}, 2, 0, 1'b0, 1'b0};
        tbl[2] = '{8'd254, 8'd1,  '{4'h1, 4'h2, 4'h3, 4'h4}, '{8'h21, 8'h43}, 2, 0, 1'b0, 1'b0};
        tbl[3] = '{8'd9,   8'd9,  '{4'hD, 4'h0, 4'h0, 4'h0}, '{8'h0D, 8'h00}, 1, 0, 1'b0, 1'b1};
        tbl[4] = '{8'd0,   8'd3,  '{4'h0, 4'h1, 4'hF, 4'h7}, '{8'h10, 8'h7F}, 2, 5, 1'b0, 1'b0};

        for (int i = 0; i < N; i++) regfile[i] = 4'h0;

        #2 reset_in = 1'b0;
        #2;
        check("reset busy", busy_out, 0);
        check("reset valid", byte_valid_out, 0);
        check("reset done", done_out, 0);
        check("reset data", byte_data_out, 0);
        check("reset addr", read_register_address_out, 0);
        repeat (2) @(negedge clock_in);
        reset_in = 1'b1;

        for (int t = 0; t < 5; t++) begin
            exp_t e;
            for (int k = 0; k < 4; k++) regfile[(int'(tbl[t].f) + k) % N] = tbl[t].r[k];
            exp_q.delete();
            for (int k = 0; k < tbl[t].nb; k++) begin
                e.data = tbl[t].b[k];
                e.last = (k == tbl[t].nb - 1);
                exp_q.push_back(e);
            end
            do_dump(tbl[t].f, tbl[t].l, 100, tbl[t].stall, tbl[t].lat, tbl[t].pulse,
                    $sformatf("vec%0d", t));
        end

        // Abort during the second SEND with ready high.
        regfile[0] = 4'h0; regfile[1] = 4'h1; regfile[2] = 4'hF; regfile[3] = 4'h7;
        @(negedge clock_in);
        start_in = 1'b1; first_address_in = 8'd0; last_address_in = 8'd3; byte_ready_in = 1'b1;
        @(negedge clock_in);
        start_in = 1'b0;
        begin
            int hs;
            hs = 0;
            for (int c = 0; c < 20 && !(byte_valid_out && hs == 1); c++) begin
                if (byte_valid_out) hs++;
                @(negedge clock_in);
            end
        end
        check("abort reach second send", byte_valid_out, 1);
        check("abort second byte", byte_data_out, 8'h7F);
        abort_in = 1'b1;
        @(negedge clock_in);
        abort_in = 1'b0;
        byte_ready_in = 1'b0;
        check("abort valid", byte_valid_out, 0);
        check("abort busy", busy_out, 0);
        check("abort last", byte_last_out, 0);
        check("abort done", done_out, 0);
        repeat (3) begin
            @(negedge clock_in);
            check("abort no done", done_out, 0);
            check("abort stays idle", busy_out, 0);
        end

        // Asynchronous reset in the middle of READ_HI.
        @(negedge clock_in);
        start_in = 1'b1; first_address_in = 8'd0; last_address_in = 8'd3;
        @(negedge clock_in);
        start_in = 1'b0;
        @(negedge clock_in);
        check("pre-reset busy", busy_out, 1);
        #1 reset_in = 1'b0;
        #1;
        check("mid reset busy", busy_out, 0);
        check("mid reset valid", byte_valid_out, 0);
        check("mid reset last", byte_last_out, 0);
        check("mid reset done", done_out, 0);
        check("mid reset data", byte_data_out, 0);
        check("mid reset addr", read_register_address_out, 0);
        @(negedge clock_in);
        reset_in = 1'b1;
        regfile[0] = 4'h5; regfile[1] = 4'hA;
        exp_q.delete();
        begin
            exp_t e;
            e.data = 8'hA5;
            e.last = 1'b1;
            exp_q.push_back(e);
        end
        do_dump(8'd0, 8'd1, 100, 0, 1'b0, 1'b0, "post-reset");

        // Random ranges and contents with random backpressure.
        for (int r = 0; r < 12; r++) begin
            logic [7:0] f, l;
            for (int i = 0; i < N; i++) regfile[i] = 4'($urandom);
            f = (r % 3 == 0) ? 8'($urandom_range(248, 255)) : 8'($urandom_range(0, 255));
            l = 8'((int'(f) + $urandom_range(0, 11)) % N);
            build_model(f, l);
            do_dump(f, l, 60, 0, 1'b0, 1'b0, $sformatf("rand%0d", r));
        end

        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end

endmodule
